cc_coeff_sequencer: RTL and testbench

- Control block placed in front of colorspace_conversion; owns the 3x3 signed colour-correction coefficient set that drives that block's cc_coeff input.
- Software writes go into a shadow bank; a commit copies shadow to active only at a frame boundary.
- Before the copy, the upstream pixel stream is stalled and all in-flight pixels are drained, so every pixel of a frame uses one consistent coefficient set.
- Also generates colorspace_conversion's data_ready and tracks its in-flight pixel count.

---
 rtl/cc_coeff_sequencer.sv | 163 ++++++++++++++++
 tb/tb_cc_coeff_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_coeff_sequencer.sv
// cc_coeff_sequencer: shadow/active colour-correction coefficient bank.
// Commits swap banks at a frame boundary after the pipeline drains.
module cc_coeff_sequencer #(
    parameter int COEFF_W      = 12,
    parameter int FRAC_BITS    = 6,
    parameter int MAX_INFLIGHT = 8,
    parameter int CNT_W        = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cfg_we,
    input  logic [3:0]                        cfg_addr,
    input  logic signed [COEFF_W-1:0]         cfg_wdata,
    input  logic                              cfg_commit,
    output logic                              cfg_busy,
    output logic                              cfg_err,
    input  logic                              frame_start,
    input  logic                              src_valid,
    output logic                              src_ready,
    output logic                              cc_data_ready,
    input  logic                              cc_data_valid,
    output logic signed [8:0][COEFF_W-1:0]    cc_coeff,
    output logic [CNT_W-1:0]                  inflight,
    output logic                              swap_done
);

    typedef enum logic [1:0] {
        S_RUN,
        S_ARMED,
        S_DRAIN,
        S_SWAP
    } state_e;

    localparam logic [COEFF_W-1:0] ONE =
        COEFF_W'(2 ** FRAC_BITS);
    localparam logic [COEFF_W-1:0] ZERO = '0;
    localparam logic [8:0][COEFF_W-1:0] IDENT = {
        ONE, ZERO, ZERO,
        ZERO, ONE, ZERO,
        ZERO, ZERO, ONE
    };
    localparam logic [CNT_W-1:0] MAX_CNT =
        CNT_W'(MAX_INFLIGHT);
    localparam logic [3:0] LAST_IDX = 4'd8;

    state_e                    state_q;
    state_e                    state_d;
    logic [8:0][COEFF_W-1:0]   shadow_q;
    logic [8:0][COEFF_W-1:0]   shadow_d;
    logic [8:0][COEFF_W-1:0]   active_q;
    logic [8:0][COEFF_W-1:0]   active_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;
    logic                      err_q;
    logic                      err_d;

    logic busy;
    logic swap;
    logic rdy;
    logic room;
    logic accept;
    logic retire;
    logic wr_ok;
    logic addr_bad;

    assign room   = (cnt_q < MAX_CNT);
    assign accept = src_valid & src_ready;
    assign retire = cc_data_valid & (cnt_q != '0);

    // Sequencer: next state, stall gating and busy/swap strobes.
    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        swap    = 1'b0;
        rdy     = 1'b0;
        unique case (state_q)
            S_RUN: begin
                busy = 1'b0;
                rdy  = room;
                if (cfg_commit) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                // first pixel of the new frame waits for new coefficients
                rdy = room & ~frame_start;
                if (frame_start) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                swap    = 1'b1;
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Shadow writes and rejection of illegal writes/commits.
    always_comb begin
        shadow_d = shadow_q;
        addr_bad = (cfg_addr > LAST_IDX);
        wr_ok    = cfg_we & ~addr_bad & ~busy;
        err_d    = (cfg_we & (addr_bad | busy))
                 | (cfg_commit & busy);
        for (int k = 0; k < 9; k++) begin
            if (wr_ok && cfg_addr == 4'(k)) begin
                shadow_d[k] = cfg_wdata;
            end
        end
    end

    // Active bank only moves during the swap cycle.
    always_comb begin
        active_d = active_q;
        if (swap) begin
            active_d = shadow_q;
        end
    end

    // In-flight count: accepts in, results out, empty results ignored.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (retire && !accept) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State registers with synchronous reset to identity banks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RUN;
            shadow_q <= IDENT;
            active_q <= IDENT;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign src_ready     = rdy & ~reset;
    assign cc_data_ready = src_valid & src_ready;
    assign cfg_busy      = busy;
    assign cfg_err       = err_q;
    assign swap_done     = swap;
    assign inflight      = cnt_q;
    assign cc_coeff      = active_q;

endmodule

// File: tb/tb_cc_coeff_sequencer.sv
// tb_cc_coeff_sequencer: directed + random bench with a
// behavioural model of the commit/drain/swap protocol.
module tb_cc_coeff_sequencer;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_we;
    logic [3:0]        cfg_addr;
    logic [11:0]       cfg_wdata;
    logic              cfg_commit;
    logic              cfg_busy;
    logic              cfg_err;
    logic              frame_start;
    logic              src_valid;
    logic              src_ready;
    logic              cc_data_ready;
    logic              cc_data_valid;
    logic [8:0][11:0]  cc_coeff;
    logic [3:0]        inflight;
    logic              swap_done;

    int checks   = 0;
    int failures = 0;

    cc_coeff_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_commit    (cfg_commit),
        .cfg_busy      (cfg_busy),
        .cfg_err       (cfg_err),
        .frame_start   (frame_start),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .cc_data_ready (cc_data_ready),
        .cc_data_valid (cc_data_valid),
        .cc_coeff      (cc_coeff),
        .inflight      (inflight),
        .swap_done     (swap_done)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string nm, input bit act,
                        input bit exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b want %0b @%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chkn(input string nm, input int act,
                        input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d @%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm,
                        input logic [8:0][11:0] act,
                        input logic [8:0][11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0][11:0] ident();
        logic [8:0][11:0] b;
        b = '0;
        b[0] = 12'd64;
        b[4] = 12'd64;
        b[8] = 12'd64;
        return b;
    endfunction

    // ---------------- behavioural model ----------------
    logic [8:0][11:0] m_shadow;
    logic [8:0][11:0] m_active;
    int m_cnt   = 0;
    bit m_pend  = 0;
    bit m_drain = 0;
    bit m_swap  = 0;
    bit m_err   = 0;
    bit m_ok    = 0;

    always @(negedge clk) begin : model
        bit busy;
        bit rdy;
        bit acc;
        bit dec;
        busy = m_pend | m_drain | m_swap;
        rdy  = !reset && (m_cnt < 8) && !m_drain && !m_swap
               && !(m_pend && frame_start);
        acc  = src_valid && rdy;
        if (m_ok) begin
            chk1("m_src_ready", src_ready, rdy);
            chk1("m_data_ready", cc_data_ready, acc);
            chk1("m_busy", cfg_busy, busy);
            chk1("m_err", cfg_err, m_err);
            chk1("m_swap_done", swap_done, m_swap);
            chkn("m_inflight", int'(inflight), m_cnt);
            chkb("m_coeff", cc_coeff, m_active);
        end
        if (reset) begin
            m_shadow = ident();
            m_active = ident();
            m_cnt    = 0;
            m_pend   = 0;
            m_drain  = 0;
            m_swap   = 0;
            m_err    = 0;
            m_ok     = 1;
        end else begin
            m_err = (cfg_we && (cfg_addr > 8 || busy))
                    || (cfg_commit && busy);
            if (m_swap) begin
                m_active = m_shadow;
                m_swap   = 0;
            end else if (m_drain) begin
                if (m_cnt == 0) begin
                    m_drain = 0;
                    m_swap  = 1;
                end
            end else if (m_pend) begin
                if (frame_start) begin
                    m_pend  = 0;
                    m_drain = 1;
                end
            end else if (cfg_commit) begin
                m_pend = 1;
            end
            if (cfg_we && cfg_addr <= 8 && !busy)
                m_shadow[cfg_addr] = cfg_wdata;
            dec   = cc_data_valid && (m_cnt > 0);
            m_cnt = m_cnt + int'(acc) - int'(dec);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cfg_we        = 0;
        cfg_addr      = 0;
        cfg_wdata     = 0;
        cfg_commit    = 0;
        frame_start   = 0;
        src_valid     = 0;
        cc_data_valid = 0;
    endtask

    task automatic wait_swap(input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (swap_done) seen = 1;
            else tick();
        end
        chk1(nm, seen, 1'b1);
    endtask

    int vals [9] = '{124, -71, 11, -14, 105, -28, 1, -33, 96};
    logic [8:0][11:0] newset;
    int extra;

    initial begin
        for (int k = 0; k < 9; k++)
            newset[k] = 12'(vals[k]);
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
        chkn("rst_c8", int'(cc_coeff[8]), 64);
        chkn("rst_c4", int'(cc_coeff[4]), 64);
        chkn("rst_c0", int'(cc_coeff[0]), 64);
        chkn("rst_c1", int'(cc_coeff[1]), 0);
        chk1("rst_ready", src_ready, 1'b1);
        chkn("rst_inflight", int'(inflight), 0);
        chk1("rst_busy", cfg_busy, 1'b0);
        tick();

        // load shadow and commit
        for (int k = 0; k < 9; k++) begin
            cfg_we    = 1;
            cfg_addr  = 4'(k);
            cfg_wdata = 12'(vals[k]);
            tick();
        end
        cfg_we     = 0;
        cfg_commit = 1;
        tick();
        cfg_commit = 0;
        #1;
        chk1("armed_busy", cfg_busy, 1'b1);
        src_valid = 1;
        tick();
        tick();
        tick();
        frame_start = 1;
        #1;
        chk1("fs_ready", src_ready, 1'b0);
        chk1("fs_dready", cc_data_ready, 1'b0);
        tick();
        frame_start = 0;
        src_valid   = 0;
        #1;
        chkn("drain_cnt", int'(inflight), 3);
        for (int i = 0; i < 3; i++) begin
            cc_data_valid = 1;
            #1;
            chk1("drain_hold", swap_done, 1'b0);
            tick();
        end
        cc_data_valid = 0;
        wait_swap("swap1_seen");
        chkb("swap1_old", cc_coeff, ident());
        tick();
        #1;
        chkb("swap1_new", cc_coeff, newset);
        chk1("swap1_ready", src_ready, 1'b1);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (swap_done) extra++;
            tick();
        end
        chkn("swap1_once", extra, 0);

        // rejected writes and commit
        cfg_we    = 1;
        cfg_addr  = 4'd9;
        cfg_wdata = 12'd500;
        tick();
        cfg_we = 0;
        #1;
        chk1("err_addr9", cfg_err, 1'b1);
        tick();
        chk1("err_clear", cfg_err, 1'b0);
        cfg_commit = 1;
        tick();
        cfg_commit = 0;
        cfg_we     = 1;
        cfg_addr   = 4'd0;
        cfg_wdata  = 12'd7;
        tick();
        cfg_we = 0;
        #1;
        chk1("err_busy_wr", cfg_err, 1'b1);
        cfg_commit = 1;
        tick();
        cfg_commit = 0;
        #1;
        chk1("err_busy_cm", cfg_err, 1'b1);
        frame_start = 1;
        tick();
        frame_start = 0;
        wait_swap("swap2_seen");
        tick();
        #1;
        chkb("shadow_kept", cc_coeff, newset);

        // saturation at MAX_INFLIGHT
        src_valid = 1;
        for (int i = 0; i < 10; i++) tick();
        chkn("full_cnt", int'(inflight), 8);
        chk1("full_ready", src_ready, 1'b0);
        tick();
        chkn("full_hold", int'(inflight), 8);
        src_valid     = 0;
        cc_data_valid = 1;
        tick();
        chkn("dec_cnt", int'(inflight), 7);
        src_valid = 1;
        #1;
        chk1("both_ready", src_ready, 1'b1);
        tick();
        chkn("both_cnt", int'(inflight), 7);
        src_valid = 0;
        for (int i = 0; i < 5; i++) tick();
        cc_data_valid = 0;

        // reset in DRAIN
        cfg_commit = 1;
        tick();
        cfg_commit  = 0;
        frame_start = 1;
        tick();
        frame_start = 0;
        #1;
        chkn("drain2_cnt", int'(inflight), 2);
        chk1("drain2_busy", cfg_busy, 1'b1);
        reset = 1;
        #1;
        chk1("rst_gate", src_ready, 1'b0);
        tick();
        reset = 0;
        #1;
        chk1("rst2_busy", cfg_busy, 1'b0);
        chkn("rst2_cnt", int'(inflight), 0);
        chkb("rst2_coeff", cc_coeff, ident());
        chk1("rst2_swap", swap_done, 1'b0);
        chk1("rst2_ready", src_ready, 1'b1);
        for (int i = 0; i < 4; i++) tick();

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 299) == 0);
            cfg_we        = ($urandom_range(0, 3) == 0);
            cfg_addr      = 4'($urandom_range(0, 10));
            cfg_wdata     = 12'($urandom);
            cfg_commit    = ($urandom_range(0, 15) == 0);
            frame_start   = ($urandom_range(0, 7) == 0);
            src_valid     = ($urandom_range(0, 3) != 0);
            cc_data_valid = ($urandom_range(0, 1) == 0);
            tick();
        end
        reset = 0;
        idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
